// File: rtl/prog_loader.sv
// Serial-link program loader: receives a length-prefixed frame of 32-bit words,
// writes them into instruction memory and releases the CPU when the frame is complete.
module prog_loader #(
  parameter int AW = 6
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_req,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_run,
  output logic        ovf
);

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, WRITE, DONE} state_t;

  state_t      r_state;
  logic [15:0] r_n;
  logic [15:0] r_idx;
  logic [1:0]  r_bcnt;
  logic [31:0] r_word;
  logic        r_ovf;

  state_t      w_state_next;
  logic [15:0] w_n_next;
  logic [15:0] w_idx_next;
  logic [1:0]  w_bcnt_next;
  logic [31:0] w_word_next;
  logic        w_ovf_next;
  logic        w_xfer;
  logic        w_in_range;
  logic [31:0] w_idx_wide;
  logic [16:0] w_idx_inc;
  logic [15:0] w_n_lo_hdr;

  // Index compare is done 17 bits wide so N=65535 terminates without wrapping.
  assign w_idx_wide = {16'd0, r_idx};
  assign w_in_range = ((w_idx_wide >> AW) == 32'd0);
  assign w_idx_inc  = {1'b0, r_idx} + 17'd1;
  assign w_n_lo_hdr = {r_n[15:8], in_data};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= HDR_HI;
      r_n     <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_n     <= w_n_next;
      r_idx   <= w_idx_next;
      r_bcnt  <= w_bcnt_next;
      r_word  <= w_word_next;
      r_ovf   <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_n_next     = r_n;
    w_idx_next   = r_idx;
    w_bcnt_next  = r_bcnt;
    w_word_next  = r_word;
    w_ovf_next   = r_ovf;
    in_ready     = (r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == DATA);
    w_xfer       = in_valid && in_ready;
    im_we        = 1'b0;
    im_addr      = '0;
    im_wdata     = '0;
    cpu_run      = (r_state == DONE);
    ovf          = r_ovf;

    if (r_state == WRITE) begin
      im_addr  = {14'd0, r_idx, 2'b00};
      im_wdata = r_word;
    end

    // A restart request wins over everything, including a pending write or byte.
    if (load_req) begin
      w_state_next = HDR_HI;
      w_n_next     = '0;
      w_idx_next   = '0;
      w_bcnt_next  = '0;
      w_word_next  = '0;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        HDR_HI: begin
          if (w_xfer) begin
            w_n_next     = {in_data, r_n[7:0]};
            w_state_next = HDR_LO;
          end
        end
        HDR_LO: begin
          if (w_xfer) begin
            w_n_next     = w_n_lo_hdr;
            w_idx_next   = '0;
            w_bcnt_next  = '0;
            w_state_next = (w_n_lo_hdr == 16'd0) ? DONE : DATA;
          end
        end
        DATA: begin
          if (w_xfer) begin
            w_word_next = {r_word[23:0], in_data};
            w_bcnt_next = r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              w_state_next = WRITE;
            end
          end
        end
        WRITE: begin
          im_we      = w_in_range;
          w_idx_next = w_idx_inc[15:0];
          if (!w_in_range) begin
            w_ovf_next = 1'b1;
          end
          w_state_next = (w_idx_inc == {1'b0, r_n}) ? DONE : DATA;
        end
        DONE: begin
        end
        default: w_state_next = HDR_HI;
      endcase
    end
  end

endmodule
